// File: rtl/ebus_xact_ctl_pkg.sv
// Shared EBUS definitions: function codes, driver record and the transaction state encoding.
// EBUS numbers data bits MSB-first; here EBUS bit 0 corresponds to vector bit DW-1.
package kl10_ebus_pkg;

  typedef enum logic [2:0] {
    FUNC_CONO  = 3'b000,
    FUNC_CONI  = 3'b001,
    FUNC_DATAO = 3'b010,
    FUNC_DATAI = 3'b011
  } tEBUSfunction;

  localparam int EBUS_DW = 36;

  typedef struct packed {
    logic               drv;
    logic [EBUS_DW-1:0] data;
  } tEBUSdriver;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DEMAND    = 2'd1,
    S_WAIT_XFER = 2'd2,
    S_FINISH    = 2'd3
  } tEbusXactState;

  // Codes 1xx are not EBUS functions.
  function automatic logic func_valid(input logic [2:0] f);
    return ~f[2];
  endfunction

  // CONI and DATAI are the reads; both have bit 0 set.
  function automatic logic func_is_read(input logic [2:0] f);
    return f[0];
  endfunction

endpackage

// File: rtl/ebus_xact_ctl_if.sv
// EBUS device-side bundle: per-device driver records in, merged data and control strobes out.
interface ebus_xact_ctl_if #(
  parameter int N_DRV = 8,
  parameter int DW    = 36
);
  logic [N_DRV*DW-1:0] drv_data;
  logic [N_DRV-1:0]    drv_en;
  logic                ebus_ack;
  logic                ebus_xfer;
  logic [DW-1:0]       ebus_data;
  logic [6:0]          ebus_cs;
  logic [2:0]          ebus_func;
  logic                ebus_demand;

  modport master (
    input  drv_data, drv_en, ebus_ack, ebus_xfer,
    output ebus_data, ebus_cs, ebus_func, ebus_demand
  );

  modport slave (
    output drv_data, drv_en, ebus_ack, ebus_xfer,
    input  ebus_data, ebus_cs, ebus_func, ebus_demand
  );
endinterface

// File: rtl/ebus_xact_ctl_drv_mux.sv
// Wired-OR merge of N_IN driver slices (slice k at bits k*DW) with a more-than-one-driver flag.
module ebus_drv_mux #(
  parameter int N_IN = 9,
  parameter int DW   = 36
) (
  input  logic [N_IN*DW-1:0] in_data,
  input  logic [N_IN-1:0]    in_en,
  output logic [DW-1:0]      out_data,
  output logic               conflict
);

  logic any_drv;

  always_comb begin
    out_data = '0;
    conflict = 1'b0;
    any_drv  = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (in_en[k]) begin
        out_data = out_data | in_data[k*DW +: DW];
        conflict = conflict | any_drv;
        any_drv  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ebus_xact_ctl.sv
// EBOX-side EBUS transaction controller: demand/ack/xfer handshake with per-phase timeout,
// plus the bus data merge with the latched write word as an implicit extra driver.
//
// state       | meaning
// S_IDLE      | waiting for start; bus demand low
// S_DEMAND    | demand high, waiting for device ack
// S_WAIT_XFER | demand high, waiting for device xfer
// S_FINISH    | demand dropped, done pulse, back to idle
module ebus_xact_ctl
  import kl10_ebus_pkg::*;
#(
  parameter int N_DRV = 8,
  parameter int DW    = 36,
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       cs_in,
  input  logic [2:0]       func_in,
  input  logic [DW-1:0]    wdata,
  input  logic [TMO_W-1:0] tmo_limit,
  ebus_xact_ctl_if.master  bus,
  output logic [DW-1:0]    rdata,
  output logic             busy,
  output logic             done,
  output logic             err_tmo,
  output logic             err_conflict,
  output logic             err_func
);

  tEbusXactState    state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [6:0]       cs_q;
  logic [2:0]       func_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata_q;
  logic             err_tmo_q, err_conflict_q, err_func_q;

  logic             accept, reject, set_tmo, capture;
  logic             demand_ph, imp_en;
  logic [DW-1:0]    mux_data;
  logic             mux_conflict;

  assign demand_ph = (state_q == S_DEMAND) || (state_q == S_WAIT_XFER);
  assign imp_en    = demand_ph && !func_is_read(func_q);

  ebus_drv_mux #(
    .N_IN (N_DRV + 1),
    .DW   (DW)
  ) u_drv_mux (
    .in_data  ({wdata_q, bus.drv_data}),
    .in_en    ({imp_en, bus.drv_en}),
    .out_data (mux_data),
    .conflict (mux_conflict)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    reject  = 1'b0;
    set_tmo = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (func_valid(func_in)) begin
            accept  = 1'b1;
            state_d = S_DEMAND;
            cnt_d   = '0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_DEMAND, S_WAIT_XFER: begin
        // The handshake event outranks a timeout landing in the same cycle.
        if (state_q == S_DEMAND && bus.ebus_ack) begin
          state_d = S_WAIT_XFER;
          cnt_d   = '0;
        end else if (state_q == S_WAIT_XFER && bus.ebus_xfer) begin
          capture = func_is_read(func_q);
          state_d = S_FINISH;
        end else if (cnt_q == tmo_limit) begin
          set_tmo = 1'b1;
          state_d = S_FINISH;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      cs_q           <= '0;
      func_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      err_tmo_q      <= 1'b0;
      err_conflict_q <= 1'b0;
      err_func_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_func_q <= reject;
      if (accept) begin
        cs_q           <= cs_in;
        func_q         <= func_in;
        wdata_q        <= wdata;
        err_tmo_q      <= 1'b0;
        err_conflict_q <= 1'b0;
      end
      if (set_tmo) err_tmo_q <= 1'b1;
      if (busy && mux_conflict) err_conflict_q <= 1'b1;
      if (capture) rdata_q <= mux_data;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_FINISH);
  assign bus.ebus_demand = demand_ph;
  assign bus.ebus_data   = mux_data;
  assign bus.ebus_cs     = cs_q;
  assign bus.ebus_func   = func_q;
  assign rdata           = rdata_q;
  assign err_tmo         = err_tmo_q;
  assign err_conflict    = err_conflict_q;
  assign err_func        = err_func_q;

endmodule

// File: tb/tb_ebus_xact_ctl.sv
// Directed bench for ebus_xact_ctl: reads, writes, timeout, conflicts, reset abort, ack+xfer overlap.
module tb_ebus_xact_ctl;
  localparam int N_DRV = 8;
  localparam int DW    = 36;
  localparam int TMO_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [6:0]       cs_in;
  logic [2:0]       func_in;
  logic [DW-1:0]    wdata;
  logic [TMO_W-1:0] tmo_limit;
  logic [DW-1:0]    rdata;
  logic             busy, done, err_tmo, err_conflict, err_func;

  int checks   = 0;
  int failures = 0;

  ebus_xact_ctl_if #(.N_DRV(N_DRV), .DW(DW)) bus_if ();

  ebus_xact_ctl #(.N_DRV(N_DRV), .DW(DW), .TMO_W(TMO_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cs_in        (cs_in),
    .func_in      (func_in),
    .wdata        (wdata),
    .tmo_limit    (tmo_limit),
    .bus          (bus_if),
    .rdata        (rdata),
    .busy         (busy),
    .done         (done),
    .err_tmo      (err_tmo),
    .err_conflict (err_conflict),
    .err_func     (err_func)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a one-cycle start; on return the DUT has taken the edge that samples it.
  task automatic issue(input logic [6:0] cs, input logic [2:0] f,
                       input logic [DW-1:0] wd, input logic [TMO_W-1:0] tmo);
    cs_in = cs; func_in = f; wdata = wd; tmo_limit = tmo; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if ({busy, done, bus_if.ebus_demand, err_tmo, err_conflict, err_func} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000",
        {busy, done, bus_if.ebus_demand, err_tmo, err_conflict, err_func});
    end
    checks++; if (rdata !== '0 || bus_if.ebus_cs !== 7'o0 || bus_if.ebus_data !== '0) begin
      failures++; $display("FAIL reset_data rdata=%0o cs=%0o data=%0o exp=0",
        rdata, bus_if.ebus_cs, bus_if.ebus_data);
    end
  endtask

  task automatic test_datai();
    issue(7'o20, 3'b011, '0, 8'd20);
    checks++; if (busy !== 1'b1 || bus_if.ebus_demand !== 1'b1 || bus_if.ebus_cs !== 7'o20
                  || bus_if.ebus_func !== 3'b011) begin
      failures++; $display("FAIL datai_demand busy=%b dem=%b cs=%0o func=%b exp 1 1 20 011",
        busy, bus_if.ebus_demand, bus_if.ebus_cs, bus_if.ebus_func);
    end
    tick(); tick();
    bus_if.ebus_ack = 1'b1;
    tick();
    bus_if.ebus_ack = 1'b0;
    bus_if.drv_en[3] = 1'b1;
    bus_if.drv_data[3*DW +: DW] = 36'o123456654321;
    tick();
    bus_if.ebus_xfer = 1'b1;
    #1;
    checks++; if (bus_if.ebus_data !== 36'o123456654321 || done !== 1'b0) begin
      failures++; $display("FAIL datai_bus data=%0o done=%b exp 123456654321 0", bus_if.ebus_data, done);
    end
    tick();
    bus_if.ebus_xfer = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b1 || bus_if.ebus_demand !== 1'b0
                  || rdata !== 36'o123456654321 || err_tmo !== 1'b0 || err_conflict !== 1'b0) begin
      failures++; $display("FAIL datai_finish done=%b busy=%b dem=%b rdata=%0o tmo=%b cfl=%b",
        done, busy, bus_if.ebus_demand, rdata, err_tmo, err_conflict);
    end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL datai_idle done=%b busy=%b exp 0 0", done, busy);
    end
    bus_if.drv_en = '0;
    bus_if.drv_data = '0;
  endtask

  task automatic test_cono();
    issue(7'o4, 3'b000, 36'o777, 8'd20);
    #1;
    checks++; if (bus_if.ebus_data !== 36'o777) begin
      failures++; $display("FAIL cono_data_demand got=%0o exp=777", bus_if.ebus_data);
    end
    bus_if.ebus_ack = 1'b1;
    tick();
    bus_if.ebus_ack = 1'b0;
    checks++; if (bus_if.ebus_data !== 36'o777 || bus_if.ebus_demand !== 1'b1) begin
      failures++; $display("FAIL cono_data_wait data=%0o dem=%b exp 777 1", bus_if.ebus_data, bus_if.ebus_demand);
    end
    bus_if.ebus_xfer = 1'b1;
    tick();
    bus_if.ebus_xfer = 1'b0;
    checks++; if (done !== 1'b1 || rdata !== 36'o123456654321 || bus_if.ebus_data !== '0) begin
      failures++; $display("FAIL cono_finish done=%b rdata=%0o data=%0o exp 1 123456654321 0",
        done, rdata, bus_if.ebus_data);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    issue(7'o1, 3'b000, '0, 8'd5);
    for (int i = 0; i < 20; i++) begin
      if (bus_if.ebus_demand !== 1'b1) break;
      n++;
      tick();
    end
    checks++; if (n != 6) begin
      failures++; $display("FAIL tmo_demand_cycles got=%0d exp=6", n);
    end
    checks++; if (done !== 1'b1 || err_tmo !== 1'b1 || bus_if.ebus_demand !== 1'b0) begin
      failures++; $display("FAIL tmo_finish done=%b tmo=%b dem=%b exp 1 1 0", done, err_tmo, bus_if.ebus_demand);
    end
    tick();
    checks++; if (err_tmo !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL tmo_sticky tmo=%b busy=%b exp 1 0", err_tmo, busy);
    end
    issue(7'o1, 3'b011, '0, 8'd0);
    checks++; if (err_tmo !== 1'b0 || bus_if.ebus_demand !== 1'b1) begin
      failures++; $display("FAIL tmo_clear tmo=%b dem=%b exp 0 1", err_tmo, bus_if.ebus_demand);
    end
    tick();
    checks++; if (done !== 1'b1 || err_tmo !== 1'b1) begin
      failures++; $display("FAIL tmo_zero_limit done=%b tmo=%b exp 1 1", done, err_tmo);
    end
    tick();
  endtask

  task automatic test_conflict();
    issue(7'o3, 3'b001, '0, 8'd20);
    bus_if.drv_en[1] = 1'b1; bus_if.drv_data[1*DW +: DW] = 36'o1;
    bus_if.drv_en[5] = 1'b1; bus_if.drv_data[5*DW +: DW] = 36'o4;
    bus_if.ebus_ack = 1'b1;
    tick();
    bus_if.ebus_ack = 1'b0;
    checks++; if (err_conflict !== 1'b1) begin
      failures++; $display("FAIL conflict_flag got=%b exp=1", err_conflict);
    end
    bus_if.ebus_xfer = 1'b1;
    tick();
    bus_if.ebus_xfer = 1'b0;
    checks++; if (rdata !== 36'o5 || done !== 1'b1) begin
      failures++; $display("FAIL conflict_rdata rdata=%0o done=%b exp 5 1", rdata, done);
    end
    bus_if.drv_en = '0;
    tick();
    // Clear the sticky flag with a quiet transaction, then conflict while idle.
    issue(7'o3, 3'b011, '0, 8'd0);
    tick(); tick();
    bus_if.drv_en[1] = 1'b1;
    bus_if.drv_en[5] = 1'b1;
    tick(); tick();
    checks++; if (err_conflict !== 1'b0 || bus_if.ebus_data !== 36'o5) begin
      failures++; $display("FAIL conflict_idle flag=%b data=%0o exp 0 5", err_conflict, bus_if.ebus_data);
    end
    bus_if.drv_en[5] = 1'b0;
    issue(7'o3, 3'b010, 36'o10, 8'd0);
    #1;
    checks++; if (bus_if.ebus_data !== 36'o11) begin
      failures++; $display("FAIL conflict_implicit_data got=%0o exp=11", bus_if.ebus_data);
    end
    tick();
    checks++; if (err_conflict !== 1'b1 || done !== 1'b1) begin
      failures++; $display("FAIL conflict_implicit flag=%b done=%b exp 1 1", err_conflict, done);
    end
    bus_if.drv_en = '0;
    bus_if.drv_data = '0;
    tick();
  endtask

  task automatic test_reset_abort();
    issue(7'o20, 3'b011, '0, 8'd20);
    bus_if.ebus_ack = 1'b1;
    tick();
    bus_if.ebus_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || bus_if.ebus_demand !== 1'b0 || done !== 1'b0 || bus_if.ebus_cs !== 7'o0) begin
      failures++; $display("FAIL abort busy=%b dem=%b done=%b cs=%0o exp 0 0 0 0",
        busy, bus_if.ebus_demand, done, bus_if.ebus_cs);
    end
    rst_n = 1'b1;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_after done=%b busy=%b exp 0 0", done, busy);
    end
    issue(7'o5, 3'b110, '0, 8'd20);
    checks++; if (err_func !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL bad_func_pulse err_func=%b busy=%b exp 1 0", err_func, busy);
    end
    tick();
    checks++; if (err_func !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL bad_func_clear err_func=%b busy=%b exp 0 0", err_func, busy);
    end
  endtask

  task automatic test_back_to_back();
    bus_if.drv_en[0] = 1'b1;
    bus_if.drv_data[0 +: DW] = 36'o42;
    issue(7'o7, 3'b011, '0, 8'd20);
    bus_if.ebus_ack = 1'b1;
    bus_if.ebus_xfer = 1'b1;
    tick();
    bus_if.ebus_ack = 1'b0;
    checks++; if (done !== 1'b0 || bus_if.ebus_demand !== 1'b1 || rdata === 36'o42) begin
      failures++; $display("FAIL overlap_wait done=%b dem=%b rdata=%0o exp 0 1 not-42",
        done, bus_if.ebus_demand, rdata);
    end
    tick();
    bus_if.ebus_xfer = 1'b0;
    checks++; if (done !== 1'b1 || rdata !== 36'o42) begin
      failures++; $display("FAIL overlap_finish done=%b rdata=%0o exp 1 42", done, rdata);
    end
    issue(7'o7, 3'b001, '0, 8'd20);
    checks++; if (busy !== 1'b0) begin
      failures++; $display("FAIL finish_start_ignored busy=%b exp 0", busy);
    end
    tick();
    checks++; if (busy !== 1'b0 || bus_if.ebus_demand !== 1'b0) begin
      failures++; $display("FAIL finish_start_idle busy=%b dem=%b exp 0 0", busy, bus_if.ebus_demand);
    end
    bus_if.drv_en = '0;
    bus_if.drv_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cs_in = '0; func_in = '0; wdata = '0; tmo_limit = '0;
    bus_if.drv_data = '0; bus_if.drv_en = '0; bus_if.ebus_ack = 1'b0; bus_if.ebus_xfer = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_datai();
    test_cono();
    test_timeout();
    test_conflict();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ebus_xact_ctl.md
Name: ebus_xact_ctl

Overview:
- EBOX-side EBUS transaction controller plus a generalised N-driver data mux.
- Issues CONO/CONI/DATAO/DATAI transfers with controller select and demand, and waits for ack then xfer, each with a programmable timeout.
- Merges per-device driver records (data plus a one-hot driving flag) onto the bus, detects multi-driver conflicts, and captures read data.
- Sits between the EBOX microcode sequencer and the shared EBUS device side (DTE, APR, PI, MTR).

Parameters:
- N_DRV, 8, number of device drivers muxed onto EBUS data.
- DW, 36, EBUS data width; bit 0 is MSB.
- TMO_W, 8, width of the ack/xfer timeout counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a transaction; ignored unless idle
- cs_in  in  7  controller select for the transaction
- func_in  in  3  EBUS function code (CONO=000, CONI=001, DATAO=010, DATAI=011; other codes rejected)
- wdata  in  DW  write data for CONO/DATAO
- tmo_limit  in  TMO_W  cycles allowed per wait phase
- drv_data  in  N_DRV*DW  packed driver data, driver k at slice k
- drv_en  in  N_DRV  per-driver driving flags
- ebus_ack  in  1  device acknowledge
- ebus_xfer  in  1  device transfer done
- ebus_data  out  DW  merged bus data
- ebus_cs  out  7  registered controller select
- ebus_func  out  3  registered function
- ebus_demand  out  1  demand strobe
- rdata  out  DW  captured read data
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- err_tmo  out  1  sticky timeout flag, cleared by next accepted start
- err_conflict  out  1  sticky multi-driver flag, cleared by next accepted start
- err_func  out  1  one-cycle pulse on rejected function code

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs 0, state IDLE, counter 0.
  - Mid-transaction reset aborts immediately; no done pulse.
- States: IDLE, DEMAND, WAIT_XFER, FINISH.
- IDLE + start with a valid func:
  - Latch cs, func, wdata.
  - Next cycle: DEMAND, busy=1, ebus_demand=1, counter cleared.
- IDLE + start with an invalid func (1xx): err_func pulses one cycle; stay IDLE.
- DEMAND:
  - ebus_demand held at 1.
  - ebus_ack=1 → WAIT_XFER, counter cleared.
  - Otherwise the counter increments. Counter==tmo_limit → err_tmo=1, go to FINISH.
- WAIT_XFER:
  - ebus_demand held at 1.
  - ebus_xfer=1 → capture rdata (CONI/DATAI only; write functions leave rdata unchanged), go to FINISH.
  - Timeout handled as in DEMAND.
  - ack and xfer both high in DEMAND: ack is taken first; xfer is sampled next cycle.
- FINISH:
  - ebus_demand=0, done=1 for one cycle, busy=0 on the following cycle.
  - Returns to IDLE. A start in FINISH is ignored.
- tmo_limit=0: timeout in the first wait cycle unless ack/xfer is already high (ack/xfer take priority over timeout in the same cycle).
- Counter saturates; it never wraps.
- Data mux (combinational):
  - ebus_data = OR of drv_data slices whose drv_en is set.
  - During DEMAND/WAIT_XFER of CONO/DATAO, latched wdata is ORed in as implicit driver N_DRV.
  - Zero drivers → all zeros.
- Conflict:
  - More than one active driver, counting the implicit one, in any busy cycle sets err_conflict (registered).
  - Data is still the OR.
  - Conflicts while idle are not flagged.
- rdata captures the mux output in the xfer cycle.

Decomposition:
- Shared package kl10_ebus_pkg:
  - tEBUSfunction enum, func code constants.
  - tEBUSdriver packed struct generalised by a DW parameter.
  - State enum tEbusXactState.
- One natural sub-module: ebus_drv_mux, a parametrised OR-mux with a population-count >1 conflict detector (N_DRV+1 inputs).
- FSM and timeout counter live in ebus_xact_ctl.

Test Plan:
- DATAI, cs=7'o20, driver 3 drives 36'o123456_654321 with xfer 2 cycles after ack (ack at cycle 3) → rdata=36'o123456654321, done pulses once, no errors.
- CONO, wdata=36'o777, no drivers → ebus_data=36'o777 while demand is high; ack then xfer → done; rdata unchanged.
- tmo_limit=5, no ack → err_tmo=1 after 6 demand cycles, done pulse, demand drops; next start clears err_tmo.
- CONI with drivers 1 and 5 both enabled (values 36'o1, 36'o4) → rdata=36'o5, err_conflict=1.
- rst_n low during WAIT_XFER → next cycle busy=0, demand=0, no done; func_in=3'b110 start → err_func pulse, stays idle.
- ack and xfer asserted together on the first DEMAND cycle → WAIT_XFER, then capture next cycle; done 3 cycles after start.
